// File: rtl/tank_pkg.sv
// tank_pkg: shared life width, winner codes and round state encoding for the tank game blocks.
package tank_pkg;
    localparam int LIFE_W = 2;
    localparam logic [LIFE_W-1:0] LIFE_MAX = 2'b11;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1 = 2'b01;
    localparam logic [1:0] WIN_T2 = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    typedef enum logic {ST_PLAY, ST_OVER} state_t;
endpackage

// File: rtl/invuln_timer.sv
// invuln_timer: post-hit invulnerability window, active for exactly INVULN_CYCLES cycles after start.
module invuln_timer #(
    parameter int INVULN_CYCLES = 500000,
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic start,
    output logic active
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(INVULN_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic active_q, active_d;
    always_comb begin
        cnt_d = cnt_q;
        active_d = active_q;
        if (clr) begin
            cnt_d = '0;
            active_d = 1'b0;
        end else if (start) begin
            cnt_d = LOAD;
            active_d = 1'b1;
        end else if (active_q) begin
            // Stay high through the cycle where the count sits at zero, drop on the next edge.
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            active_d = (cnt_q != '0);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            active_q <= active_d;
        end
    end
    assign active = active_q;
endmodule

// File: rtl/tank_life_tracker.sv
// tank_life_tracker: per-tank life counters with invulnerability windows and win/draw/game-over tracking.
module tank_life_tracker
    import tank_pkg::*;
#(
    parameter int INIT_LIFE = 3,
    parameter int INVULN_CYCLES = 500000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       restart,
    output logic [1:0] tank1_life,
    output logic [1:0] tank2_life,
    output logic       invuln1,
    output logic       invuln2,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam logic [LIFE_W-1:0] INIT = LIFE_W'(INIT_LIFE);
    state_t state_q, state_d;
    logic [LIFE_W-1:0] l1_q, l1_d, l2_q, l2_d;
    logic [1:0] win_q, win_d;
    logic acc1, acc2, z1, z2;
    always_comb begin
        acc1 = (state_q == ST_PLAY) && hit1 && !invuln1 && (l1_q != '0) && !restart;
        acc2 = (state_q == ST_PLAY) && hit2 && !invuln2 && (l2_q != '0) && !restart;
        l1_d = restart ? INIT : l1_q - LIFE_W'(acc1);
        l2_d = restart ? INIT : l2_q - LIFE_W'(acc2);
        z1 = (l1_d == '0);
        z2 = (l2_d == '0);
        state_d = state_q;
        win_d = win_q;
        if (restart) begin
            state_d = ST_PLAY;
            win_d = WIN_NONE;
        end else if (state_q == ST_PLAY && (z1 || z2)) begin
            state_d = ST_OVER;
            win_d = (z1 && z2) ? WIN_DRAW : z1 ? WIN_T2 : WIN_T1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PLAY;
            l1_q <= INIT;
            l2_q <= INIT;
            win_q <= WIN_NONE;
        end else begin
            state_q <= state_d;
            l1_q <= l1_d;
            l2_q <= l2_d;
            win_q <= win_d;
        end
    end
    invuln_timer #(.INVULN_CYCLES(INVULN_CYCLES), .CNT_W(CNT_W)) u_inv1 (
        .clk(clk), .rst(rst), .clr(restart), .start(acc1), .active(invuln1)
    );
    invuln_timer #(.INVULN_CYCLES(INVULN_CYCLES), .CNT_W(CNT_W)) u_inv2 (
        .clk(clk), .rst(rst), .clr(restart), .start(acc2), .active(invuln2)
    );
    assign tank1_life = l1_q;
    assign tank2_life = l2_q;
    assign winner = win_q;
    assign game_over = (state_q == ST_OVER);
endmodule

// File: tb/tb_tank_life_tracker.sv
// tb_tank_life_tracker: cycle-by-cycle vector table plus hand sequences, expectations queued and checked after each edge.
module tb_tank_life_tracker;
    logic clk = 1'b0, rst = 1'b0, hit1 = 1'b0, hit2 = 1'b0, restart = 1'b0;
    logic [1:0] tank1_life, tank2_life, winner;
    logic invuln1, invuln2, game_over;
    typedef struct {
        logic rst, rs, h1, h2;
        logic [1:0] l1, l2;
        logic i1, i2, go;
        logic [1:0] w;
    } vec_t;
    vec_t tbl[$];
    vec_t exp_q[$];
    int tests = 0, fails = 0;

    tank_life_tracker #(.INIT_LIFE(3), .INVULN_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .hit1(hit1), .hit2(hit2), .restart(restart),
        .tank1_life(tank1_life), .tank2_life(tank2_life),
        .invuln1(invuln1), .invuln2(invuln2), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, rs, h1, h2, input logic [1:0] l1, l2,
                                input logic i1, i2, go, input logic [1:0] w);
        vec_t v;
        v.rst = r; v.rs = rs; v.h1 = h1; v.h2 = h2;
        v.l1 = l1; v.l2 = l2; v.i1 = i1; v.i2 = i2; v.go = go; v.w = w;
        return v;
    endfunction

    task automatic add(input int n, input vec_t v);
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; restart = v.rs; hit1 = v.h1; hit2 = v.h2;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("tank1_life", int'(tank1_life), int'(e.l1));
        chk("tank2_life", int'(tank2_life), int'(e.l2));
        chk("invuln1", int'(invuln1), int'(e.i1));
        chk("invuln2", int'(invuln2), int'(e.i2));
        chk("game_over", int'(game_over), int'(e.go));
        chk("winner", int'(winner), int'(e.w));
    endtask

    initial begin
        //        cnt   rst rs h1 h2   l1 l2 i1 i2 go  w
        add(2,  mk(1, 0, 1, 0,  3, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 0, 0,  3, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 0, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 1, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 0, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 0, 0,  2, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 0,  1, 3, 1, 0, 0, 0));
        add(3,  mk(0, 0, 0, 0,  1, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 0, 0,  1, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 0, 1,  1, 2, 0, 1, 0, 0));
        add(3,  mk(0, 0, 0, 0,  1, 2, 0, 1, 0, 0));
        add(2,  mk(0, 0, 0, 0,  1, 2, 0, 0, 0, 0));
        add(1,  mk(0, 0, 0, 1,  1, 1, 0, 1, 0, 0));
        add(3,  mk(0, 0, 0, 0,  1, 1, 0, 1, 0, 0));
        add(2,  mk(0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        add(1,  mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 1));
        add(1,  mk(0, 0, 1, 0,  1, 0, 0, 1, 1, 1));
        add(2,  mk(0, 0, 0, 0,  1, 0, 0, 1, 1, 1));
        add(1,  mk(0, 0, 1, 1,  1, 0, 0, 0, 1, 1));
        add(1,  mk(0, 1, 1, 0,  3, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 1,  2, 2, 1, 1, 0, 0));
        add(3,  mk(0, 0, 0, 0,  2, 2, 1, 1, 0, 0));
        add(1,  mk(0, 0, 0, 0,  2, 2, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 1,  1, 1, 1, 1, 0, 0));
        add(3,  mk(0, 0, 0, 0,  1, 1, 1, 1, 0, 0));
        add(1,  mk(0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 1,  0, 0, 1, 1, 1, 3));
        add(1,  mk(0, 1, 1, 0,  3, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 1, 0, 0,  3, 3, 0, 0, 0, 0));
        add(1,  mk(0, 0, 1, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 0, 0,  2, 3, 1, 0, 0, 0));
        add(1,  mk(0, 0, 0, 1,  2, 2, 1, 1, 0, 0));
        add(1,  mk(1, 0, 0, 1,  3, 3, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        // tank1 worn down alone: three hits each followed by a full window
        for (int k = 0; k < 3; k++) begin
            step(mk(0, 0, 1, 0, 2'(2 - k), 3, 1, 0, k == 2, (k == 2) ? 2'b10 : 2'b00));
            for (int j = 0; j < 4; j++)
                step(mk(0, 0, 1, 0, 2'(2 - k), 3, j < 3, 0, k == 2, (k == 2) ? 2'b10 : 2'b00));
        end
        step(mk(1, 0, 0, 0, 3, 3, 0, 0, 0, 0));
        step(mk(0, 0, 0, 1, 3, 2, 0, 1, 0, 0));
        @(negedge clk);
        rst = 1'b0; restart = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tank_life_tracker.md
Name: tank_life_tracker

Overview:
- Owns the life counters of both tanks: consumes single-cycle hit pulses from the collision detector, applies a per-tank post-hit invulnerability window, and tracks win/draw/game-over.
- Drives the 2-bit tank1_life/tank2_life buses consumed directly by the piezo sound block and the score display.
- Life change on either bus triggers the hit sound; a zero life triggers the victory tune.

Parameters:
- INIT_LIFE, 3, life value loaded at reset/restart; 1..3, fits 2 bits.
- INVULN_CYCLES, 500000, clk cycles a tank ignores hits after being hit (0.5 s at 1 MHz).
- CNT_W, 20, invulnerability counter width; must satisfy 2^CNT_W > INVULN_CYCLES.

Ports:
- clk  in  1  system clock, one domain.
- rst  in  1  synchronous reset, active-high.
- hit1  in  1  single-cycle pulse: tank1 struck.
- hit2  in  1  single-cycle pulse: tank2 struck.
- restart  in  1  single-cycle pulse: start a new round.
- tank1_life  out  2  registered tank1 life, 0..INIT_LIFE.
- tank2_life  out  2  registered tank2 life, 0..INIT_LIFE.
- invuln1  out  1  high while tank1 is invulnerable (display blink).
- invuln2  out  1  high while tank2 is invulnerable.
- game_over  out  1  high in GAME_OVER state.
- winner  out  2  00 none, 01 tank1 won, 10 tank2 won, 11 draw.

Behaviour:
- Reset (rst=1 at a clk edge):
  - tankN_life=INIT_LIFE; invulnN=0; counters=0; game_over=0; winner=00; state=PLAY.
  - Reset overrides every other input.
- Priority: rst > restart > hits.
- States: PLAY, GAME_OVER.
- Hits in PLAY:
  - A hitN sampled high while invulnN=0 and tankN_life>0 decrements tankN_life, visible at edge N+1 (1-cycle latency).
  - The same edge loads counterN=INVULN_CYCLES-1 and sets invulnN=1.
- Invulnerability window:
  - counterN decrements once per cycle while invulnN=1.
  - invulnN clears on the edge after counterN reaches 0, so invulnN is high for exactly INVULN_CYCLES cycles.
  - hitN is ignored while invulnN=1; no counter reload, no life change.
- Both tanks hit in the same cycle: each tank is evaluated independently and both may decrement.
- Life saturates at 0 and never wraps to 3.
- PLAY -> GAME_OVER occurs on the same edge a life reaches 0:
  - only tank2_life becomes 0: winner=01.
  - only tank1_life becomes 0: winner=10.
  - both become 0 on the same edge: winner=11.
  - game_over=1 on that edge.
- GAME_OVER:
  - hits are ignored; lives hold; invulnerability counters continue to expire normally.
  - winner and game_over hold until restart or rst.
- restart pulse, in either state, at the next edge:
  - lives=INIT_LIFE; counters=0; invulnN=0; winner=00; game_over=0; state=PLAY.
  - A hit in the same cycle as restart is dropped.
- restart during PLAY is a mid-round reset: same effect as above.
- Lives never increase except through rst or restart.
- All outputs are registers; there are no combinational input-to-output paths.

Decomposition:
- Shared package tank_pkg:
  - LIFE_W=2 and LIFE_MAX=2'b11.
  - winner encoding constants WIN_NONE/WIN_T1/WIN_T2/WIN_DRAW.
  - state encoding ST_PLAY/ST_OVER.
  - Also used by the piezo and display blocks.
- One sub-module, invuln_timer:
  - ports: clk, rst, clr, start, active.
  - parameters: INVULN_CYCLES, CNT_W.
  - instantiated once per tank.
- The top holds the FSM, the life registers and the winner logic.

Test Plan (bench uses INVULN_CYCLES=4, INIT_LIFE=3):
- rst high 2 cycles -> tank1_life=3, tank2_life=3, invuln1/2=0, game_over=0, winner=00; hit1 held during rst has no effect.
- hit1 pulse at cycle 10 -> tank1_life=2 at edge 11; invuln1 high cycles 11..14; hit1 at cycle 12 ignored (life stays 2); hit1 at cycle 16 -> tank1_life=1.
- hit2 three times spaced 6 cycles apart -> tank2_life 3->2->1->0; on the third, game_over=1 and winner=01 on the same edge; a further hit1 leaves tank1_life unchanged.
- Both lives at 1, hit1 and hit2 in the same cycle -> both 0 on the next edge, winner=11, game_over=1.
- In GAME_OVER, restart pulse together with hit1 -> next edge lives=3/3, winner=00, game_over=0, invuln1=0 (hit dropped).
- Mid-round: tank1_life=2 with invuln1 active, restart -> lives=3/3, invuln1=0; an immediate hit1 is accepted -> tank1_life=2.
